dll_lock_ctrl: RTL and testbench
================================

Name: dll_lock_ctrl

Overview:
- Lock controller for the delay-locked loop core.
- Sequences the delay-line tap code from phase-detector samples: settle after each code step, majority-vote a window of samples, then step the code up, down or hold.
- Declares lock after repeated direction reversals and clears lock when tracking drifts.
- Sits between the phase detector and the delay line inside the tt_um_dpetrisko_ttdll top.

Parameters:
- CODE_W, 6, width of the delay-line tap code.
- SETTLE_CYC, 4, cycles to wait after a code change before sampling.
- AVG_LOG2, 3, decision window is 2^AVG_LOG2 valid samples.
- LOCK_REV, 4, consecutive direction reversals required to assert lock.

Ports:
- clk  in  1  system clock; only clock.
- rst  in  1  reset, synchronous, active-high.
- en_i  in  1  run enable; low forces IDLE.
- pd_valid_i  in  1  phase-detector sample qualifier.
- pd_late_i  in  1  1 = delayed edge is late (code must decrease); sampled only when pd_valid_i=1.
- code_init_i  in  CODE_W  starting code, loaded on IDLE exit.
- code_o  out  CODE_W  tap code to the delay line.
- locked_o  out  1  lock indication.
- sat_o  out  1  code pinned at a bound by a decision.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge, overrides en_i, any state):
  - state IDLE; code_o=0, locked_o=0, sat_o=0, busy_o=0.
  - All counters and direction history cleared.
- States: IDLE, SETTLE, SAMPLE, DECIDE.
- IDLE, en_i=1: next cycle code_o=code_init_i, state=SETTLE, settle counter=SETTLE_CYC, rev_cnt=0, direction history=none, sat_o=0.
- SETTLE:
  - Stays exactly SETTLE_CYC cycles, then goes to SAMPLE.
  - pd_valid_i is ignored.
- SAMPLE:
  - Each cycle with pd_valid_i=1 increments sample_cnt and adds pd_late_i to late_cnt.
  - On the cycle the 2^AVG_LOG2-th valid sample is taken, next state is DECIDE.
  - Gaps in pd_valid_i extend SAMPLE indefinitely.
- DECIDE (one cycle; code_o updates at the DECIDE edge, visible the following cycle):
  - half = 2^(AVG_LOG2-1).
  - late_cnt > half: dir=DN. late_cnt < half: dir=UP.
  - late_cnt == half (tie): no step; code, rev_cnt and history unchanged; next state SAMPLE (no settle).
  - DN at code 0, or UP at code 2^CODE_W-1 (saturation):
    - code unchanged, sat_o=1, rev_cnt=0, locked_o=0;
    - history updated to dir; next state SAMPLE.
  - Otherwise (normal step):
    - code += 1 (UP) or -= 1 (DN), no wrap; sat_o=0.
    - If history != none and dir != history: rev_cnt += 1, saturating at LOCK_REV.
    - If dir == history: rev_cnt=0 and locked_o=0.
    - locked_o=1 when rev_cnt reaches LOCK_REV.
    - history=dir; next state SETTLE.
  - sample_cnt and late_cnt clear on every DECIDE exit.
- en_i=0 in any non-IDLE state:
  - next cycle IDLE; code_o holds last value; locked_o=0, sat_o=0.
  - Partial sample window discarded.
- busy_o is combinational from state.

Test Plan:
- Reset: rst=1 for 2 cycles mid-SAMPLE with en_i=1 -> code_o=0, locked_o=0, sat_o=0, busy_o=0 the cycle after; IDLE until en_i re-seen.
- Monotonic descent (default params): code_init_i=32, en_i=1, pd_valid_i=1, pd_late_i=1 constant -> code_o=32 one cycle after en_i; code_o=31 after 1+4+8+1 cycles; then −1 every 13 cycles; locked_o stays 0.
- Saturation: code_init_i=1, pd_late_i=1 always -> code_o=0 after first decision; next decision sat_o=1, code_o stays 0; later decisions spaced 9 cycles (no settle).
- Lock: code_init_i=20, bench drives pd_late_i=(code_o>=20) -> codes 19,20,19,20,19; locked_o=1 after 5th decision. Then force pd_late_i=1 -> locked_o=0 at the first step repeating the previous direction.
- Tie and gaps: 4 late of 8 valid samples with pd_valid_i toggling every other cycle -> code_o unchanged, rev_cnt unchanged, next window begins without SETTLE.
- Enable drop: en_i=0 after 3 samples -> IDLE next cycle, code_o held, locked_o=0; en_i=1 again reloads code_init_i.

Source files
------------

// File: rtl/dll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// dll_lock_ctrl
//   Lock controller for the delay-locked loop core. It walks the delay-line tap
//   code using phase-detector samples. After every code step it waits for the
//   line to settle. It then majority-votes a window of valid samples and steps
//   the code up or down, or holds it. Lock is declared after a run of direction
//   reversals and is dropped when two consecutive steps go the same way.
//
// Ports
//   clk          system clock (only clock)
//   rst          synchronous active-high reset
//   en_i         run enable; low returns the controller to IDLE
//   pd_valid_i   phase-detector sample qualifier
//   pd_late_i    1 = delayed edge late (code must decrease); used when valid
//   code_init_i  starting code, loaded when leaving IDLE
//   code_o       tap code to the delay line
//   locked_o     lock indication
//   sat_o        last decision hit a code bound
//   busy_o       controller not in IDLE
// -----------------------------------------------------------------------------
module dll_lock_ctrl #(
  parameter int CODE_W     = 6,
  parameter int SETTLE_CYC = 4,
  parameter int AVG_LOG2   = 3,
  parameter int LOCK_REV   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              pd_valid_i,
  input  logic              pd_late_i,
  input  logic [CODE_W-1:0] code_init_i,
  output logic [CODE_W-1:0] code_o,
  output logic              locked_o,
  output logic              sat_o,
  output logic              busy_o
);

  localparam int WIN   = 1 << AVG_LOG2;
  localparam int HALF  = WIN / 2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int SET_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int REV_W = (LOCK_REV < 1) ? 1 : $clog2(LOCK_REV + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DECIDE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  state_t             state_reg, state_next;
  dir_t               hist_reg, hist_next;
  dir_t               dir;
  logic [CODE_W-1:0]  code_reg, code_next;
  logic               locked_reg, locked_next;
  logic               sat_reg, sat_next;
  logic [SET_W-1:0]   settle_cnt_reg, settle_cnt_next;
  logic [CNT_W-1:0]   sample_cnt_reg, sample_cnt_next;
  logic [CNT_W-1:0]   late_cnt_reg, late_cnt_next;
  logic [REV_W-1:0]   rev_cnt_reg, rev_cnt_next;
  logic [REV_W-1:0]   rev_inc;
  logic               at_bound;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      hist_reg       <= DIR_NONE;
      code_reg       <= '0;
      locked_reg     <= 1'b0;
      sat_reg        <= 1'b0;
      settle_cnt_reg <= '0;
      sample_cnt_reg <= '0;
      late_cnt_reg   <= '0;
      rev_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      hist_reg       <= hist_next;
      code_reg       <= code_next;
      locked_reg     <= locked_next;
      sat_reg        <= sat_next;
      settle_cnt_reg <= settle_cnt_next;
      sample_cnt_reg <= sample_cnt_next;
      late_cnt_reg   <= late_cnt_next;
      rev_cnt_reg    <= rev_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hist_next       = hist_reg;
    code_next       = code_reg;
    locked_next     = locked_reg;
    sat_next        = sat_reg;
    settle_cnt_next = settle_cnt_reg;
    sample_cnt_next = sample_cnt_reg;
    late_cnt_next   = late_cnt_reg;
    rev_cnt_next    = rev_cnt_reg;
    // Majority vote: more late samples than half means the code must come down.
    dir      = (late_cnt_reg > CNT_W'(HALF)) ? DIR_DN : DIR_UP;
    at_bound = (dir == DIR_DN) ? (code_reg == '0) : (code_reg == {CODE_W{1'b1}});
    // The reversal count sticks at LOCK_REV so that lock holds while the loop dithers.
    rev_inc  = (rev_cnt_reg == REV_W'(LOCK_REV)) ? rev_cnt_reg : rev_cnt_reg + REV_W'(1);

    if (state_reg != IDLE && !en_i) begin
      // Disable wins over any in-flight step; the code is held for the delay line.
      state_next      = IDLE;
      locked_next     = 1'b0;
      sat_next        = 1'b0;
      sample_cnt_next = '0;
      late_cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (en_i) begin
            state_next      = SETTLE;
            code_next       = code_init_i;
            settle_cnt_next = SET_W'(SETTLE_CYC);
            rev_cnt_next    = '0;
            hist_next       = DIR_NONE;
            sat_next        = 1'b0;
            sample_cnt_next = '0;
            late_cnt_next   = '0;
          end
        end
        SETTLE: begin
          // The last settle cycle is the one with the count at 1.
          if (settle_cnt_reg <= SET_W'(1)) state_next = SAMPLE;
          else settle_cnt_next = settle_cnt_reg - SET_W'(1);
        end
        SAMPLE: begin
          if (pd_valid_i) begin
            sample_cnt_next = sample_cnt_reg + CNT_W'(1);
            late_cnt_next   = late_cnt_reg + CNT_W'(pd_late_i);
            if (sample_cnt_reg == CNT_W'(WIN - 1)) state_next = DECIDE;
          end
        end
        DECIDE: begin
          sample_cnt_next = '0;
          late_cnt_next   = '0;
          if (late_cnt_reg == CNT_W'(HALF)) begin
            // Tie: the code has not moved, so there is nothing to settle.
            state_next = SAMPLE;
          end else if (at_bound) begin
            sat_next     = 1'b1;
            rev_cnt_next = '0;
            locked_next  = 1'b0;
            hist_next    = dir;
            state_next   = SAMPLE;
          end else begin
            code_next = (dir == DIR_UP) ? code_reg + CODE_W'(1) : code_reg - CODE_W'(1);
            sat_next  = 1'b0;
            if (hist_reg != DIR_NONE && dir != hist_reg) begin
              rev_cnt_next = rev_inc;
              if (rev_inc == REV_W'(LOCK_REV)) locked_next = 1'b1;
            end else if (dir == hist_reg) begin
              rev_cnt_next = '0;
              locked_next  = 1'b0;
            end
            hist_next       = dir;
            settle_cnt_next = SET_W'(SETTLE_CYC);
            state_next      = SETTLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign code_o   = code_reg;
  assign locked_o = locked_reg;
  assign sat_o    = sat_reg;
  assign busy_o   = (state_reg != IDLE);

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dll_lock_ctrl
//   Self-checking bench for dll_lock_ctrl using the default parameters. Each
//   scenario task pushes expected {code, locked, sat, busy} values onto a
//   scoreboard. Each value is tagged with the cycle number, counted from the
//   first enabled edge, at which it must appear. The task pops and compares
//   each entry when that cycle is reached. Outputs are sampled on the falling
//   edge, and inputs are driven there as well.
// -----------------------------------------------------------------------------
module tb_dll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b0;
  logic       pd_valid_i = 1'b0;
  logic       pd_late_i = 1'b0;
  logic [5:0] code_init_i = '0;
  logic [5:0] code_o;
  logic       locked_o, sat_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         t;
    logic [5:0] code;
    logic       locked;
    logic       sat;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  dll_lock_ctrl #(.CODE_W(6), .SETTLE_CYC(4), .AVG_LOG2(3), .LOCK_REV(4)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .pd_valid_i(pd_valid_i), .pd_late_i(pd_late_i),
    .code_init_i(code_init_i), .code_o(code_o), .locked_o(locked_o), .sat_o(sat_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void push_exp(int t, logic [5:0] c, logic l, logic s, logic b);
    exp_t x;
    x.t = t; x.code = c; x.locked = l; x.sat = s; x.busy = b;
    sb.push_back(x);
  endfunction

  // Leaves the DUT in IDLE. The task ends on a falling edge with rst low.
  task automatic do_reset();
    rst = 1'b1; en_i = 1'b0; pd_valid_i = 1'b0; pd_late_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({code_o, locked_o, sat_o, busy_o} !== {6'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got code=%0d l=%b s=%b b=%b want 0/0/0/0",
               code_o, locked_o, sat_o, busy_o);
    end
    code_init_i = 6'd10; en_i = 1'b1; pd_valid_i = 1'b1; pd_late_i = 1'b0;
    push_exp(1, 10, 0, 0, 1);
    push_exp(7, 10, 0, 0, 1);
    push_exp(8, 0, 0, 0, 0);
    push_exp(9, 0, 0, 0, 0);
    push_exp(10, 10, 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t == i) begin
        e = sb.pop_front(); n_tests++;
        if ({code_o, locked_o, sat_o, busy_o} !== {e.code, e.locked, e.sat, e.busy}) begin
          n_fail++;
          $display("FAIL reset t=%0d: got code=%0d l=%b s=%b b=%b want code=%0d l=%b s=%b b=%b",
                   i, code_o, locked_o, sat_o, busy_o, e.code, e.locked, e.sat, e.busy);
        end
      end
      // Reset is held across the edges at cycles 8 and 9, with en_i still high.
      if (i == 7) rst = 1'b1;
      if (i == 9) rst = 1'b0;
    end
  endtask

  task automatic test_descent();
    do_reset();
    code_init_i = 6'd32; en_i = 1'b1; pd_valid_i = 1'b1; pd_late_i = 1'b1;
    push_exp(1, 32, 0, 0, 1);
    // First decision lands 1+4+8+1 edges in. After that, one step every 4+8+1 edges.
    for (int k = 0; k < 4; k++) begin
      push_exp(13 + 13 * k, 6'(32 - k), 0, 0, 1);
      push_exp(14 + 13 * k, 6'(31 - k), 0, 0, 1);
    end
    for (int i = 1; i <= 53; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t == i) begin
        e = sb.pop_front(); n_tests++;
        if ({code_o, locked_o, sat_o, busy_o} !== {e.code, e.locked, e.sat, e.busy}) begin
          n_fail++;
          $display("FAIL descent t=%0d: got code=%0d l=%b s=%b b=%b want code=%0d l=%b s=%b b=%b",
                   i, code_o, locked_o, sat_o, busy_o, e.code, e.locked, e.sat, e.busy);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    code_init_i = 6'd1; en_i = 1'b1; pd_valid_i = 1'b1; pd_late_i = 1'b1;
    push_exp(1, 1, 0, 0, 1);
    push_exp(13, 1, 0, 0, 1);
    push_exp(14, 0, 0, 0, 1);
    push_exp(26, 0, 0, 0, 1);
    push_exp(27, 0, 0, 1, 1);
    // No settle follows a saturated decision, so the next window of 8 samples
    // ends with a decision at edge 36. That decision is an up step.
    push_exp(35, 0, 0, 1, 1);
    push_exp(36, 1, 0, 0, 1);
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t == i) begin
        e = sb.pop_front(); n_tests++;
        if ({code_o, locked_o, sat_o, busy_o} !== {e.code, e.locked, e.sat, e.busy}) begin
          n_fail++;
          $display("FAIL saturation t=%0d: got code=%0d l=%b s=%b b=%b want code=%0d l=%b s=%b b=%b",
                   i, code_o, locked_o, sat_o, busy_o, e.code, e.locked, e.sat, e.busy);
        end
      end
      if (i >= 27) pd_late_i = 1'b0;
    end
  endtask

  task automatic test_lock();
    do_reset();
    code_init_i = 6'd20; en_i = 1'b1; pd_valid_i = 1'b1; pd_late_i = 1'b1;
    push_exp(1, 20, 0, 0, 1);
    push_exp(14, 19, 0, 0, 1);
    push_exp(27, 20, 0, 0, 1);
    push_exp(40, 19, 0, 0, 1);
    push_exp(53, 20, 0, 0, 1);
    push_exp(65, 20, 0, 0, 1);
    push_exp(66, 19, 1, 0, 1);
    push_exp(78, 19, 1, 0, 1);
    push_exp(79, 18, 0, 0, 1);
    for (int i = 1; i <= 79; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t == i) begin
        e = sb.pop_front(); n_tests++;
        if ({code_o, locked_o, sat_o, busy_o} !== {e.code, e.locked, e.sat, e.busy}) begin
          n_fail++;
          $display("FAIL lock t=%0d: got code=%0d l=%b s=%b b=%b want code=%0d l=%b s=%b b=%b",
                   i, code_o, locked_o, sat_o, busy_o, e.code, e.locked, e.sat, e.busy);
        end
      end
      // Closed loop around code 20 until locked, then push it downward.
      pd_late_i = (i >= 66) ? 1'b1 : (code_o >= 6'd20);
    end
  endtask

  task automatic test_tie_gaps();
    do_reset();
    code_init_i = 6'd20; en_i = 1'b1; pd_valid_i = 1'b0; pd_late_i = 1'b0;
    push_exp(1, 20, 0, 0, 1);
    push_exp(20, 20, 0, 0, 1);
    push_exp(21, 20, 0, 0, 1);
    push_exp(36, 20, 0, 0, 1);
    push_exp(37, 19, 0, 0, 1);
    for (int i = 1; i <= 37; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t == i) begin
        e = sb.pop_front(); n_tests++;
        if ({code_o, locked_o, sat_o, busy_o} !== {e.code, e.locked, e.sat, e.busy}) begin
          n_fail++;
          $display("FAIL tie_gaps t=%0d: got code=%0d l=%b s=%b b=%b want code=%0d l=%b s=%b b=%b",
                   i, code_o, locked_o, sat_o, busy_o, e.code, e.locked, e.sat, e.busy);
        end
      end
      // Valid samples fall on even edges. The first window (edges 6..20) has 4
      // late samples out of 8, which is a tie. The next window is all late.
      pd_valid_i = ((i + 1) % 2 == 0);
      pd_late_i  = (i + 1 >= 22) ? 1'b1 : ((i + 1) % 4 == 0);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    code_init_i = 6'd40; en_i = 1'b1; pd_valid_i = 1'b1; pd_late_i = 1'b0;
    push_exp(1, 40, 0, 0, 1);
    push_exp(8, 40, 0, 0, 1);
    push_exp(9, 40, 0, 0, 0);
    push_exp(11, 40, 0, 0, 0);
    push_exp(12, 7, 0, 0, 1);
    push_exp(24, 7, 0, 0, 1);
    push_exp(25, 8, 0, 0, 1);
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t == i) begin
        e = sb.pop_front(); n_tests++;
        if ({code_o, locked_o, sat_o, busy_o} !== {e.code, e.locked, e.sat, e.busy}) begin
          n_fail++;
          $display("FAIL enable_drop t=%0d: got code=%0d l=%b s=%b b=%b want code=%0d l=%b s=%b b=%b",
                   i, code_o, locked_o, sat_o, busy_o, e.code, e.locked, e.sat, e.busy);
        end
      end
      // En_i drops after 3 samples (edges 6..8). It returns with a new
      // starting code.
      if (i == 8) en_i = 1'b0;
      if (i == 11) begin
        en_i = 1'b1;
        code_init_i = 6'd7;
      end
    end
  endtask

  initial begin
    test_reset();
    test_descent();
    test_saturation();
    test_lock();
    test_tie_gaps();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
